// File: rtl/dispensa_troco_pkg.sv
// Shared definitions for the vending machine FSMs: state encoding, change coin
// denominations and the default sale price.
package dispensa_troco_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    OFFER  = 2'd2,
    DONE   = 2'd3
  } estado_t;

  localparam int NUM_MOEDAS   = 3;
  localparam int PRECO_PADRAO = 40;

  // Index 0 is the smallest coin; the change selector scans from the top down.
  localparam logic [NUM_MOEDAS-1:0][4:0] MOEDAS = {5'd20, 5'd10, 5'd5};

  function automatic logic [5:0] moeda6(input logic [4:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/dispensa_troco_estoque.sv
// estoque_moeda: 4-bit stock counter for one coin denomination. Reload wins over
// decrement and the count never wraps below zero.
module estoque_moeda #(
  parameter logic [3:0] INICIAL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       carga,
  input  logic       dec,
  input  logic [3:0] valor,
  output logic [3:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     cnt <= INICIAL;
    else if (carga)                 cnt <= valor;
    else if (dec && cnt != 4'd0)    cnt <= cnt - 4'd1;
  end

endmodule

// File: rtl/dispensa_troco.sv
// Change dispenser: after a sale pays out saldo-PRECO greedily in 20/10/5 coins,
// one coin per handshake, limited by the per-denomination stock.
module dispensa_troco
  import dispensa_troco_pkg::*;
#(
  parameter int PRECO   = PRECO_PADRAO,
  parameter int STOCK5  = 8,
  parameter int STOCK10 = 4,
  parameter int STOCK20 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vendeu,
  input  logic [5:0] saldo,
  input  logic       recarga,
  input  logic       moeda_ack,
  output logic [4:0] moeda_out,
  output logic       moeda_valid,
  output logic       ocupado,
  output logic       pronto,
  output logic [4:0] residuo,
  output logic       falta_troco
);

  localparam logic [5:0] PRECO6 = 6'(PRECO);
  localparam logic [NUM_MOEDAS-1:0][3:0] RECARGA_VAL =
    {4'(STOCK20), 4'(STOCK10), 4'(STOCK5)};

  estado_t                      estado, prox;
  logic [5:0]                   troco;
  logic [NUM_MOEDAS-1:0][3:0]   stk;
  logic [NUM_MOEDAS-1:0]        dec;
  logic                         carga, aceita, achou;
  logic [4:0]                   escolha;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= IDLE;
    else        estado <= prox;
  end

  always_comb begin
    prox    = estado;
    aceita  = 1'b0;
    carga   = 1'b0;
    dec     = '0;
    achou   = 1'b0;
    escolha = '0;
    // Largest coin that fits the remaining change and is still in stock.
    for (int i = NUM_MOEDAS - 1; i >= 0; i--) begin
      if (!achou && troco >= moeda6(MOEDAS[i]) && stk[i] != 4'd0) begin
        achou   = 1'b1;
        escolha = MOEDAS[i];
      end
    end
    case (estado)
      IDLE: begin
        carga  = recarga;
        aceita = vendeu && (saldo >= PRECO6);
        if (aceita) prox = SELECT;
      end
      SELECT: prox = achou ? OFFER : DONE;
      OFFER: begin
        if (moeda_ack) begin
          prox = SELECT;
          for (int i = 0; i < NUM_MOEDAS; i++) dec[i] = (moeda_out == MOEDAS[i]);
        end
      end
      DONE:    prox = IDLE;
      default: prox = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      troco       <= '0;
      moeda_out   <= '0;
      residuo     <= '0;
      falta_troco <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (aceita) begin
            troco       <= saldo - PRECO6;
            residuo     <= '0;
            falta_troco <= 1'b0;
          end
        end
        SELECT: begin
          if (achou)                moeda_out   <= escolha;
          else if (troco >= 6'd5)   falta_troco <= 1'b1;
        end
        OFFER: begin
          if (moeda_ack) begin
            troco     <= troco - moeda6(moeda_out);
            moeda_out <= '0;
          end
        end
        DONE:    residuo <= troco[4:0];
        default: ;
      endcase
    end
  end

  assign moeda_valid = (estado == OFFER);
  assign ocupado     = (estado != IDLE);
  assign pronto      = (estado == DONE);

  for (genvar g = 0; g < NUM_MOEDAS; g++) begin : g_estoque
    estoque_moeda #(.INICIAL(RECARGA_VAL[g])) u_estoque (
      .clk   (clk),
      .reset (reset),
      .carga (carga),
      .dec   (dec[g]),
      .valor (RECARGA_VAL[g]),
      .cnt   (stk[g])
    );
  end

endmodule

// File: tb/tb_dispensa_troco.sv
// Bench for dispensa_troco: greedy change model with stock bookkeeping, random
// handshakes and input noise while the dispenser is busy.
module tb_dispensa_troco;

  localparam int PRECO     = 40;
  localparam int RELOAD[3] = '{8, 4, 2};

  logic       clk = 1'b0, reset = 1'b0;
  logic       vendeu = 1'b0, recarga = 1'b0, moeda_ack = 1'b0;
  logic [5:0] saldo = '0;
  logic [4:0] moeda_out, residuo;
  logic       moeda_valid, ocupado, pronto, falta_troco;

  int vecs = 0, errs = 0;
  int stk[3];
  int res_m = 0;
  bit falta_m = 1'b0;

  dispensa_troco dut (
    .clk(clk), .reset(reset), .vendeu(vendeu), .saldo(saldo), .recarga(recarga),
    .moeda_ack(moeda_ack), .moeda_out(moeda_out), .moeda_valid(moeda_valid),
    .ocupado(ocupado), .pronto(pronto), .residuo(residuo), .falta_troco(falta_troco)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) stk[i] = RELOAD[i];
    res_m = 0;
    falta_m = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; vendeu = 1'b0; recarga = 1'b0; moeda_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    vecs++;
    if ({moeda_out, moeda_valid, ocupado, pronto, residuo, falta_troco} !== 14'd0) begin
      errs++;
      $display("FAIL reset_outputs: got out=%0d v=%b busy=%b pronto=%b res=%0d falta=%b want all 0",
               moeda_out, moeda_valid, ocupado, pronto, residuo, falta_troco);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One sale; pol 0 = always ack, 1 = random ack, 2 = stall first offer 5 cycles.
  task automatic sale(input int s, input bit rec, input int pol, input string nm);
    logic [4:0] exp[$];
    int  t, d, idx, cyc, stall;
    int  tmp[3];
    bit  done, a, prev_valid, prev_ack;
    @(negedge clk);
    if (rec) for (int i = 0; i < 3; i++) stk[i] = RELOAD[i];
    vendeu = 1'b1; saldo = 6'(s); recarga = rec; moeda_ack = 1'($urandom % 2);
    @(negedge clk);
    vendeu = 1'b0; recarga = 1'b0; moeda_ack = 1'b0;
    if (s < PRECO) begin
      vecs++;
      if ({ocupado, residuo, falta_troco} !== {1'b0, 5'(res_m), falta_m}) begin
        errs++;
        $display("FAIL %s low_saldo: got busy=%b res=%0d falta=%b want busy=0 res=%0d falta=%b",
                 nm, ocupado, residuo, falta_troco, res_m, falta_m);
      end
      return;
    end
    t = s - PRECO;
    for (int i = 0; i < 3; i++) tmp[i] = stk[i];
    forever begin
      if (t >= 20 && tmp[2] > 0)      begin d = 20; idx = 2; end
      else if (t >= 10 && tmp[1] > 0) begin d = 10; idx = 1; end
      else if (t >= 5 && tmp[0] > 0)  begin d = 5;  idx = 0; end
      else break;
      exp.push_back(5'(d));
      tmp[idx]--;
      t -= d;
    end
    cyc = 0; stall = 0; done = 1'b0; prev_valid = 1'b0; prev_ack = 1'b0;
    while (!done && cyc < 200) begin
      if (cyc == 0) begin
        vecs++;
        if ({ocupado, moeda_valid, residuo, falta_troco} !== 8'b1000_0000) begin
          errs++;
          $display("FAIL %s select_cycle: got busy=%b v=%b res=%0d falta=%b want 1 0 0 0",
                   nm, ocupado, moeda_valid, residuo, falta_troco);
        end
      end
      if (cyc == 1) begin
        vecs++;
        if ({moeda_valid, pronto} !== {exp.size() > 0, exp.size() == 0}) begin
          errs++;
          $display("FAIL %s latency: got v=%b pronto=%b want v=%b pronto=%b",
                   nm, moeda_valid, pronto, exp.size() > 0, exp.size() == 0);
        end
      end
      if (prev_valid && !prev_ack) begin
        vecs++;
        if (moeda_valid !== 1'b1) begin
          errs++;
          $display("FAIL %s valid_hold: got v=%b want 1", nm, moeda_valid);
        end
      end
      if (prev_ack) begin
        vecs++;
        if (moeda_valid !== 1'b0) begin
          errs++;
          $display("FAIL %s coin_rate: got v=%b want 0 after ack", nm, moeda_valid);
        end
      end
      vecs++;
      if (moeda_valid) begin
        if (exp.size() == 0) begin
          errs++;
          $display("FAIL %s extra_coin: got %0d want no offer", nm, moeda_out);
        end else if (moeda_out !== exp[0]) begin
          errs++;
          $display("FAIL %s coin: got %0d want %0d", nm, moeda_out, exp[0]);
        end
      end else if (moeda_out !== 5'd0) begin
        errs++;
        $display("FAIL %s idle_coin: got %0d want 0", nm, moeda_out);
      end
      if (pronto) begin
        done = 1'b1;
        vecs++;
        if (exp.size() != 0) begin
          errs++;
          $display("FAIL %s early_pronto: got %0d coins left want 0", nm, exp.size());
        end
      end
      if (moeda_valid) begin
        if (pol == 0)      a = 1'b1;
        else if (pol == 1) a = 1'($urandom % 2);
        else if (stall < 5) begin a = 1'b0; stall++; end
        else a = 1'b1;
      end else a = 1'($urandom % 2);
      if (moeda_valid && a && exp.size() > 0) begin
        idx = (exp[0] == 5'd20) ? 2 : (exp[0] == 5'd10) ? 1 : 0;
        stk[idx]--;
        void'(exp.pop_front());
      end
      prev_valid = moeda_valid;
      prev_ack   = moeda_valid && a;
      if (done) begin
        moeda_ack = 1'b0; vendeu = 1'b0; recarga = 1'b0;
      end else begin
        moeda_ack = a;
        vendeu    = (pol == 2) ? 1'b1 : 1'($urandom % 2);
        saldo     = (pol == 2) ? 6'd63 : 6'($urandom);
        recarga   = ($urandom % 4) == 0;
      end
      @(negedge clk);
      cyc++;
    end
    moeda_ack = 1'b0; vendeu = 1'b0; recarga = 1'b0;
    if (!done) begin
      vecs++; errs++;
      $display("FAIL %s timeout: got no pronto in 200 cycles want pronto", nm);
      return;
    end
    res_m = t;
    falta_m = (t >= 5);
    vecs++;
    if ({pronto, ocupado, residuo, falta_troco} !== {2'b00, 5'(res_m), falta_m}) begin
      errs++;
      $display("FAIL %s finish: got pronto=%b busy=%b res=%0d falta=%b want 0 0 %0d %b",
               nm, pronto, ocupado, residuo, falta_troco, res_m, falta_m);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    sale(55, 1'b0, 0, "s55");
    sale(40, 1'b0, 0, "s40");
    sale(63, 1'b0, 0, "s63");
    sale(39, 1'b0, 0, "s39");
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < 7; i++) sale(60, 1'b0, 1, "exhaust");
    sale(60, 1'b1, 0, "reload_with_sale");
    sale(20, 1'b1, 0, "reload_alone");
    sale(60, 1'b0, 0, "after_reload");
  endtask

  task automatic test_stall();
    do_reset();
    sale(50, 1'b0, 2, "stall50");
    sale(60, 1'b0, 2, "stall60");
  endtask

  task automatic test_reset_mid_offer();
    int k;
    do_reset();
    sale(63, 1'b0, 0, "pre63");
    @(negedge clk);
    vendeu = 1'b1; saldo = 6'd60;
    @(negedge clk);
    vendeu = 1'b0;
    k = 0;
    while (!moeda_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    vecs++;
    if (moeda_valid !== 1'b1) begin
      errs++;
      $display("FAIL offer_reached: got v=%b want 1", moeda_valid);
    end
    moeda_ack = 1'b0;
    reset = 1'b0;
    #1;
    vecs++;
    if ({moeda_out, moeda_valid, ocupado, pronto, residuo, falta_troco} !== 14'd0) begin
      errs++;
      $display("FAIL reset_mid_offer: got out=%0d v=%b busy=%b pronto=%b res=%0d falta=%b want all 0",
               moeda_out, moeda_valid, ocupado, pronto, residuo, falta_troco);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) sale(60, 1'b0, 0, "post_reset");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++)
      sale($urandom_range(0, 63), ($urandom % 5) == 0, 1, "random");
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_exhaust();
    test_stall();
    test_reset_mid_offer();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dispensa_troco.md
DISPENSA_TROCO -- requirements
Module: dispensa_troco

Interface
REQ-001 Parameter PRECO, default 40, SHALL be the sale price in coin units.
REQ-002 Parameters STOCK5, STOCK10, STOCK20, defaults 8, 4, 2, SHALL be the reload counts of 5-, 10- and 20-unit change coins (range 0..15).
REQ-003 Port list SHALL be:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low.
- vendeu  input  1  one-cycle sale pulse from the vending FSM.
- saldo  input  6  balance at sale, sampled with vendeu.
- recarga  input  1  stock reload request.
- moeda_ack  input  1  coin ejector accepted offered coin.
- moeda_out  output  5  offered coin value (5, 10 or 20; 0 when not offering).
- moeda_valid  output  1  coin offer valid.
- ocupado  output  1  high whenever state is not IDLE.
- pronto  output  1  one-cycle pulse, change transaction finished.
- residuo  output  5  change left undispensed by the last transaction.
- falta_troco  output  1  last transaction ended with dispensable change (>=5) still owed.

Function
REQ-004 FSM states SHALL be IDLE, SELECT, OFFER, DONE.
REQ-005 IDLE: vendeu=1 and saldo>=PRECO SHALL load troco<=saldo-PRECO (6-bit, max 23), clear falta_troco and residuo, and go to SELECT.
REQ-006 IDLE: vendeu=1 with saldo<PRECO SHALL be ignored (no state change).
REQ-007 vendeu in any state other than IDLE SHALL be ignored.
REQ-008 SELECT (one cycle): troco=0 -> DONE; else choose largest d in {20,10,5} with d<=troco and stock_d>0, register moeda_out=d, go to OFFER.
REQ-009 SELECT with no eligible coin SHALL go to DONE; falta_troco<=1 if troco>=5.
REQ-010 OFFER: moeda_valid=1; moeda_out SHALL stay stable until moeda_ack is sampled high.
REQ-011 OFFER with moeda_ack=1: troco-=d, stock_d-=1, moeda_valid deasserts next cycle, go to SELECT.
REQ-012 DONE (one cycle): pronto=1, residuo<=troco, go to IDLE; residuo and falta_troco hold until the next accepted sale.
REQ-013 Latency: vendeu at edge N -> first moeda_valid from edge N+2; zero change -> pronto high in cycle after edge N+2.
REQ-014 Coin rate SHALL be at most one coin per two cycles (OFFER/SELECT alternation).
REQ-015 recarga SHALL reload all stocks to parameter values only in IDLE; elsewhere ignored.
REQ-016 recarga and vendeu together in IDLE: reload takes effect and the sale is accepted; the SELECT decision uses reloaded stocks.
REQ-017 Stock counters SHALL never underflow (decrement only on ack with stock>0).
REQ-018 moeda_ack outside OFFER SHALL be ignored.

Reset
REQ-019 reset low SHALL immediately force: state IDLE, troco 0, moeda_out 0, moeda_valid 0, pronto 0, residuo 0, falta_troco 0, stocks at STOCK5/10/20.
REQ-020 Reset mid-OFFER SHALL abort the transaction; no stock decrement and no pronto.

Structure
REQ-021 State encoding, coin values 5/10/20 and PRECO default SHALL live in a shared package used by the vending, purchase and change FSMs.
REQ-022 One sub-module SHALL be used: estoque_moeda, a 4-bit loadable down-counter with async active-low reset, instantiated per denomination.

Verification
REQ-023 saldo=55, ack always 1 -> moeda_out 10 then 5, pronto once, residuo 0, falta_troco 0, stock10=3, stock5=7.
REQ-024 saldo=40 -> no moeda_valid, pronto in cycle after edge N+2, residuo 0.
REQ-025 saldo=63 -> coins 20, then pronto with residuo 3, falta_troco 0.
REQ-026 Two sales saldo=60 (troco 20) with ack high, then saldo=60 with stock20=0 -> coins 10,10; after stock10 exhausted, saldo=60 -> 5,5,5,5.
REQ-027 saldo=50, ack low 5 cycles -> moeda_out=10 and moeda_valid stable throughout; vendeu pulses during stall ignored.
REQ-028 Reset asserted during OFFER -> all outputs zero same cycle, stocks restored to parameters.
